// File: rtl/pe_token_sink.sv
// Receive endpoint for the 36-bit PE token stream: data tokens go into a
// first-word-fall-through FIFO, control tokens are counted and pulsed.
module pe_token_sink #(
  parameter  int DEPTH = 8,
  parameter  int CW    = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [35:0]   tok_i,
  output logic          ready_o,
  input  logic          rd_en_i,
  output logic [35:0]   rd_data_o,
  output logic          rd_valid_o,
  output logic [LW-1:0] level_o,
  output logic          ctrl_pulse_o,
  output logic [CW-1:0] data_cnt_o,
  output logic [CW-1:0] ctrl_cnt_o,
  output logic          overflow_o
);

  logic [35:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q, ready_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] data_cnt_q, data_cnt_d;
  logic [CW-1:0] ctrl_cnt_q, ctrl_cnt_d;
  logic          ovf_q, ovf_d;

  logic present, is_data, is_ctrl;
  logic full, empty, push, pop, drop;

  always_comb begin
    present = (tok_i[35:33] != 3'b000);
    is_data = present & ~tok_i[32];
    is_ctrl = present &  tok_i[32];
    full    = (level_q == LW'(DEPTH));
    empty   = (level_q == '0);
    pop     = rd_en_i & ~empty;
    // A push at full is legal only when the same edge frees the head slot.
    push    = is_data & (~full | rd_en_i);
    drop    = is_data & full & ~rd_en_i;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    data_cnt_d = data_cnt_q;
    ctrl_cnt_d = ctrl_cnt_q;
    ovf_d      = ovf_q;
    pulse_d    = is_ctrl;

    if (push) begin
      wr_ptr_d   = wr_ptr_q + AW'(1);
      data_cnt_d = data_cnt_q + CW'(1);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + LW'(push) - LW'(pop);

    if (is_ctrl)
      ctrl_cnt_d = ctrl_cnt_q + CW'(1);
    if (drop)
      ovf_d = 1'b1;

    // Two-slot margin covers the one token a sender may still launch.
    ready_d = (level_d <= LW'(DEPTH - 2));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b1;
      pulse_q    <= 1'b0;
      data_cnt_q <= '0;
      ctrl_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
      pulse_q    <= pulse_d;
      data_cnt_q <= data_cnt_d;
      ctrl_cnt_q <= ctrl_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= tok_i;
  end

  assign ready_o      = ready_q;
  assign rd_valid_o   = ~empty;
  assign rd_data_o    = empty ? 36'd0 : mem_q[rd_ptr_q];
  assign level_o      = level_q;
  assign ctrl_pulse_o = pulse_q;
  assign data_cnt_o   = data_cnt_q;
  assign ctrl_cnt_o   = ctrl_cnt_q;
  assign overflow_o   = ovf_q;

endmodule
